// File: rtl/execute_muldiv_if.sv
// Operand, forwarding and result signals between ID/EX and the M-extension unit.
interface execute_muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic [2:0]      in_funct3;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_data_rs1;
    logic [XLEN-1:0] in_data_rs2;
    logic [4:0]      in_EXMEM_rd;
    logic [4:0]      in_MEMWB_rd;
    logic            in_EXMEM_write_enable;
    logic            in_MEMWB_write_enable;
    logic [XLEN-1:0] in_EXMEM_alu_out;
    logic [XLEN-1:0] in_MEMWB_out_data;
    logic            in_flush;
    logic            out_stall;
    logic            out_valid;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_busy;

    modport master (
        output in_valid, in_funct3, in_rs1, in_rs2, in_rd,
        output in_data_rs1, in_data_rs2,
        output in_EXMEM_rd, in_MEMWB_rd, in_EXMEM_write_enable, in_MEMWB_write_enable,
        output in_EXMEM_alu_out, in_MEMWB_out_data, in_flush,
        input  out_stall, out_valid, out_result, out_rd, out_busy
    );

    modport slave (
        input  in_valid, in_funct3, in_rs1, in_rs2, in_rd,
        input  in_data_rs1, in_data_rs2,
        input  in_EXMEM_rd, in_MEMWB_rd, in_EXMEM_write_enable, in_MEMWB_write_enable,
        input  in_EXMEM_alu_out, in_MEMWB_out_data, in_flush,
        output out_stall, out_valid, out_result, out_rd, out_busy
    );
endinterface

// File: rtl/execute_muldiv.sv
// RV32M/RV64M execute unit: multi-cycle multiply and 1 bit/cycle restoring divider.
module execute_muldiv #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    execute_muldiv_if.slave bus
);
    localparam int unsigned CNT_W    = $clog2(XLEN) + 1;
    localparam int unsigned MUL_LAST = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;
    localparam int unsigned DIV_LAST = XLEN - 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        funct3_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [XLEN-1:0]   div_quot_q, div_rem_q, div_dvsr_q;
    logic              q_neg_q, r_neg_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   out_result_q;
    logic [4:0]        out_rd_q;

    logic [XLEN-1:0]   op_a, op_b;
    logic              is_div, div_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, bypass_result;
    logic [1:0]        mul_f3;
    logic [XLEN-1:0]   mul_src_a, mul_src_b, mul_result;
    logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
    logic [XLEN:0]     rem_shift, trial;
    logic [XLEN-1:0]   div_quot_d, div_rem_d, div_final;

    // Operand forwarding: EX/MEM beats MEM/WB beats the register file.
    always_comb begin
        op_a = bus.in_data_rs1;
        if (bus.in_EXMEM_write_enable && bus.in_EXMEM_rd != 5'd0 && bus.in_EXMEM_rd == bus.in_rs1)
            op_a = bus.in_EXMEM_alu_out;
        else if (bus.in_MEMWB_write_enable && bus.in_MEMWB_rd != 5'd0 && bus.in_MEMWB_rd == bus.in_rs1)
            op_a = bus.in_MEMWB_out_data;
        op_b = bus.in_data_rs2;
        if (bus.in_EXMEM_write_enable && bus.in_EXMEM_rd != 5'd0 && bus.in_EXMEM_rd == bus.in_rs2)
            op_b = bus.in_EXMEM_alu_out;
        else if (bus.in_MEMWB_write_enable && bus.in_MEMWB_rd != 5'd0 && bus.in_MEMWB_rd == bus.in_rs2)
            op_b = bus.in_MEMWB_out_data;
    end

    // Accept-time divide setup: magnitudes, result signs and the bypass cases.
    always_comb begin
        is_div     = bus.in_funct3[2];
        div_signed = ~bus.in_funct3[0];
        a_neg      = div_signed & op_a[XLEN-1];
        b_neg      = div_signed & op_b[XLEN-1];
        a_mag      = a_neg ? -op_a : op_a;
        b_mag      = b_neg ? -op_b : op_b;
        div_zero   = (op_b == '0);
        div_ovf    = div_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        if (div_zero)
            bypass_result = bus.in_funct3[1] ? op_a : '1;
        else
            bypass_result = bus.in_funct3[1] ? '0 : op_a;
    end

    // Multiplier: fed straight from the forwarded operands while IDLE so a
    // single-stage configuration can retire on the accept edge.
    always_comb begin
        mul_f3    = (state_q == IDLE) ? bus.in_funct3[1:0] : funct3_q;
        mul_src_a = (state_q == IDLE) ? op_a : a_q;
        mul_src_b = (state_q == IDLE) ? op_b : b_q;
        mul_a_ext = {{XLEN{(mul_f3[0] ^ mul_f3[1]) & mul_src_a[XLEN-1]}}, mul_src_a};
        mul_b_ext = {{XLEN{(mul_f3 == 2'b01) & mul_src_b[XLEN-1]}}, mul_src_b};
        mul_prod  = mul_a_ext * mul_b_ext;
        mul_result = (mul_f3 == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    // One restoring-division step plus the sign-corrected final value.
    always_comb begin
        rem_shift = {div_rem_q, div_quot_q[XLEN-1]};
        trial     = rem_shift - {1'b0, div_dvsr_q};
        if (trial[XLEN]) begin
            div_rem_d  = rem_shift[XLEN-1:0];
            div_quot_d = {div_quot_q[XLEN-2:0], 1'b0};
        end else begin
            div_rem_d  = trial[XLEN-1:0];
            div_quot_d = {div_quot_q[XLEN-2:0], 1'b1};
        end
        if (funct3_q[1])
            div_final = r_neg_q ? -div_rem_d : div_rem_d;
        else
            div_final = q_neg_q ? -div_quot_d : div_quot_d;
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
        end else if (bus.in_flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (bus.in_valid) begin
                        funct3_q   <= bus.in_funct3[1:0];
                        rd_q       <= bus.in_rd;
                        a_q        <= op_a;
                        b_q        <= op_b;
                        cnt_q      <= '0;
                        div_quot_q <= a_mag;
                        div_rem_q  <= '0;
                        div_dvsr_q <= b_mag;
                        q_neg_q    <= a_neg ^ b_neg;
                        r_neg_q    <= a_neg;
                        if (!is_div) begin
                            if (MUL_STAGES == 1) begin
                                state_q      <= DONE;
                                out_valid_q  <= 1'b1;
                                out_result_q <= mul_result;
                                out_rd_q     <= bus.in_rd;
                            end else begin
                                state_q <= MUL;
                            end
                        end else if (div_zero || div_ovf) begin
                            state_q      <= DONE;
                            out_valid_q  <= 1'b1;
                            out_result_q <= bypass_result;
                            out_rd_q     <= bus.in_rd;
                        end else begin
                            state_q <= DIV;
                        end
                    end
                end
                MUL: begin
                    if (cnt_q == CNT_W'(MUL_LAST)) begin
                        state_q      <= DONE;
                        out_valid_q  <= 1'b1;
                        out_result_q <= mul_result;
                        out_rd_q     <= rd_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DIV: begin
                    div_quot_q <= div_quot_d;
                    div_rem_q  <= div_rem_d;
                    if (cnt_q == CNT_W'(DIV_LAST)) begin
                        state_q      <= DONE;
                        out_valid_q  <= 1'b1;
                        out_result_q <= div_final;
                        out_rd_q     <= rd_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A flush arriving during DONE squashes the strobe in that same cycle.
    assign bus.out_valid  = out_valid_q & ~bus.in_flush;
    assign bus.out_result = out_result_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_busy   = (state_q != IDLE);
    assign bus.out_stall  = ((state_q == IDLE) && bus.in_valid && !bus.in_flush) ||
                            (state_q == MUL) || (state_q == DIV);
endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv (XLEN=32, MUL_STAGES=2) with a result scoreboard.
module tb_execute_muldiv;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    execute_muldiv_if #(.XLEN(32)) bus ();
    execute_muldiv #(.XLEN(32), .MUL_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    logic [31:0] last_result;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb_, ub;
        logic [63:0] p;
        int x, y, r;
        sa  = $signed(a);
        sb_ = $signed(b);
        ub  = {32'd0, b};
        x = a;
        y = b;
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb_; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                r = x / y; return r;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                r = x % y; return r;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drives one operation, scoreboards the expectation, then follows it to completion.
    task automatic issue(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] ea, input logic [31:0] eb,
                         input logic [4:0] rd, input string tag);
        exp_t e, got;
        int cyc;
        bit seen;
        e.result = model(f3, ea, eb);
        e.rd     = rd;
        e.lat    = latency(f3, ea, eb);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_funct3 = f3; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_rd = rd; bus.in_data_rs1 = d1; bus.in_data_rs2 = d2;
        #1 check({tag, " stall_c0"}, {31'd0, bus.out_stall}, 32'd1);
        sb.push_back(e);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) begin
                seen = 1'b1;
                check({tag, " stall_done"}, {31'd0, bus.out_stall}, 32'd0);
                if (sb.size() == 0) begin
                    check({tag, " sb_empty"}, 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    check({tag, " result"}, bus.out_result, got.result);
                    check({tag, " rd"}, {27'd0, bus.out_rd}, {27'd0, got.rd});
                    check({tag, " latency"}, cyc, got.lat);
                end
            end else if (bus.out_stall !== 1'b1) begin
                check({tag, " stall_busy"}, {31'd0, bus.out_stall}, 32'd1);
            end
        end
        if (!seen) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
        @(negedge clk);
        #1;
        check({tag, " valid_1cyc"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, " idle_after"}, {31'd0, bus.out_busy}, 32'd0);
        check({tag, " hold"}, bus.out_result, e.result);
        last_result = e.result;
    endtask

    task automatic op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input string tag);
        issue(f3, 5'd1, 5'd2, a, b, a, b, rd, tag);
    endtask

    initial begin
        int nv;
        logic [31:0] ra, rb;
        logic [2:0]  rf3;
        bus.in_valid = 0; bus.in_funct3 = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0;
        bus.in_data_rs1 = 0; bus.in_data_rs2 = 0;
        bus.in_EXMEM_rd = 0; bus.in_MEMWB_rd = 0;
        bus.in_EXMEM_write_enable = 0; bus.in_MEMWB_write_enable = 0;
        bus.in_EXMEM_alu_out = 0; bus.in_MEMWB_out_data = 0; bus.in_flush = 0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst result", bus.out_result, 32'd0);
        check("rst rd", {27'd0, bus.out_rd}, 32'd0);
        check("rst stall", {31'd0, bus.out_stall}, 32'd0);
        check("rst busy", {31'd0, bus.out_busy}, 32'd0);
        reset = 1'b1;

        // Directed multiply / divide cases.
        op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3, "mul");
        op(3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 5'd4, "mulh");
        op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5, "mulhsu");
        op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, "mulhu");
        op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7, "div");
        op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8, "rem");
        op(3'd5, 32'h0000_0005, 32'h0000_0000, 5'd9, "divu_by0");
        op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, "rem_ovf");
        op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "div_ovf");
        op(3'd7, 32'h0000_0064, 32'h0000_0007, 5'd12, "remu");
        op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, "divu_big");

        // Forwarding priority.
        bus.in_EXMEM_rd = 5'd5; bus.in_EXMEM_write_enable = 1; bus.in_EXMEM_alu_out = 32'h10;
        bus.in_MEMWB_rd = 5'd5; bus.in_MEMWB_write_enable = 1; bus.in_MEMWB_out_data = 32'h20;
        issue(3'd0, 5'd5, 5'd2, 32'h99, 32'd3, 32'h10, 32'd3, 5'd14, "fwd_exmem");
        issue(3'd0, 5'd1, 5'd5, 32'd7, 32'h99, 32'd7, 32'h10, 5'd15, "fwd_rs2");
        bus.in_EXMEM_write_enable = 0;
        issue(3'd0, 5'd5, 5'd2, 32'h99, 32'd3, 32'h20, 32'd3, 5'd16, "fwd_memwb");
        bus.in_EXMEM_write_enable = 1; bus.in_EXMEM_rd = 5'd0; bus.in_MEMWB_rd = 5'd0;
        issue(3'd0, 5'd0, 5'd2, 32'h99, 32'd3, 32'h99, 32'd3, 5'd17, "fwd_x0");
        bus.in_EXMEM_write_enable = 0; bus.in_MEMWB_write_enable = 0;

        // Flush at DIV cycle 10.
        @(negedge clk);
        bus.in_valid = 1; bus.in_funct3 = 3'd4; bus.in_rs1 = 1; bus.in_rs2 = 2; bus.in_rd = 5'd20;
        bus.in_data_rs1 = 32'd100; bus.in_data_rs2 = 32'd7;
        @(negedge clk);
        bus.in_valid = 0;
        repeat (9) @(negedge clk);
        bus.in_flush = 1;
        @(negedge clk);
        bus.in_flush = 0;
        #1;
        check("flush busy", {31'd0, bus.out_busy}, 32'd0);
        check("flush stall", {31'd0, bus.out_stall}, 32'd0);
        check("flush hold", bus.out_result, last_result);
        nv = 0;
        repeat (40) begin @(negedge clk); #1; if (bus.out_valid) nv++; end
        check("flush no_valid", nv, 0);

        // Reset at DIV cycle 10.
        @(negedge clk);
        bus.in_valid = 1; bus.in_funct3 = 3'd4; bus.in_rd = 5'd21;
        @(negedge clk);
        bus.in_valid = 0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("midrst valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst result", bus.out_result, 32'd0);
        check("midrst rd", {27'd0, bus.out_rd}, 32'd0);
        check("midrst stall", {31'd0, bus.out_stall}, 32'd0);
        check("midrst busy", {31'd0, bus.out_busy}, 32'd0);
        reset = 1'b1;

        // Flush in the same cycle as an accept.
        @(negedge clk);
        bus.in_valid = 1; bus.in_flush = 1; bus.in_funct3 = 3'd0; bus.in_rd = 5'd22;
        bus.in_data_rs1 = 32'd3; bus.in_data_rs2 = 32'd5;
        #1 check("flushacc stall", {31'd0, bus.out_stall}, 32'd0);
        @(negedge clk);
        bus.in_valid = 0; bus.in_flush = 0;
        #1 check("flushacc busy", {31'd0, bus.out_busy}, 32'd0);
        nv = 0;
        repeat (4) begin @(negedge clk); #1; if (bus.out_valid) nv++; end
        check("flushacc no_valid", nv, 0);

        // in_valid during DONE is ignored.
        @(negedge clk);
        bus.in_valid = 1; bus.in_funct3 = 3'd0; bus.in_rd = 5'd23;
        bus.in_data_rs1 = 32'd6; bus.in_data_rs2 = 32'd7;
        @(negedge clk);
        bus.in_valid = 0;
        @(negedge clk);
        #1;
        check("done valid", {31'd0, bus.out_valid}, 32'd1);
        check("done result", bus.out_result, 32'd42);
        bus.in_valid = 1; bus.in_data_rs1 = 32'd9;
        @(negedge clk);
        #1;
        check("done ignore busy", {31'd0, bus.out_busy}, 32'd0);
        bus.in_valid = 0;

        // Flush while in DONE suppresses the strobe.
        @(negedge clk);
        bus.in_valid = 1; bus.in_funct3 = 3'd0; bus.in_rd = 5'd24;
        bus.in_data_rs1 = 32'd2; bus.in_data_rs2 = 32'd2;
        @(negedge clk);
        bus.in_valid = 0;
        @(negedge clk);
        bus.in_flush = 1;
        #1 check("flushdone valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        bus.in_flush = 0;
        #1;
        check("flushdone busy", {31'd0, bus.out_busy}, 32'd0);
        check("flushdone valid2", {31'd0, bus.out_valid}, 32'd0);

        // Random mix of all eight operations.
        for (int i = 0; i < 12; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            op(rf3, ra, rb, 5'($urandom_range(1, 31)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/execute_muldiv.md
EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the datapath width in bits (legal: 32 or 64).
REQ-002 The module SHALL have parameter MUL_STAGES, default 2, giving the multiply latency in cycles (legal: 1..4).
REQ-003 The module SHALL use one clock and a synchronous, active-low reset, with ports as follows:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-004 in_valid  input  1  an RV32M/RV64M operation is present in ID/EX.
REQ-005 in_funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 in_rs1, in_rs2, in_rd  input  5 each  source and destination register indices.
REQ-007 in_data_rs1, in_data_rs2  input  XLEN each  register-file operand values.
REQ-008 in_EXMEM_rd, in_MEMWB_rd  input  5 each; in_EXMEM_write_enable, in_MEMWB_write_enable  input  1 each; in_EXMEM_alu_out, in_MEMWB_out_data  input  XLEN each  forwarding sources.
REQ-009 in_flush  input  1  squash any in-flight operation.
REQ-010 out_stall  output  1  freeze IF, ID and ID/EX.
REQ-011 out_valid  output  1  one-cycle result strobe.
REQ-012 out_result  output  XLEN  result value.
REQ-013 out_rd  output  5  destination register of the result.
REQ-014 out_busy  output  1  state is not IDLE.

Function
REQ-015 Each operand SHALL be forwarded from EX/MEM when that stage's write_enable is set, its rd is nonzero and its rd equals the source index; otherwise from MEM/WB under the same conditions; otherwise from the register file. EX/MEM SHALL take priority over MEM/WB.
REQ-016 The FSM SHALL have exactly four states: IDLE, MUL, DIV, DONE.
REQ-017 An operation SHALL be accepted when state is IDLE, in_valid is 1 and in_flush is 0. On acceptance the module SHALL latch the forwarded operands, in_funct3 and in_rd.
REQ-018 From IDLE, an accepted multiply SHALL go to MUL, or directly to DONE when MUL_STAGES is 1. MUL SHALL last MUL_STAGES-1 cycles and then go to DONE. out_valid SHALL assert exactly MUL_STAGES cycles after the accept edge.
REQ-019 From IDLE, an accepted divide or remainder SHALL go to DIV and run a restoring divider at 1 bit/cycle for XLEN cycles, then go to DONE. out_valid SHALL assert XLEN+1 cycles after acceptance.
REQ-020 Divide-by-zero and signed overflow (most-negative value / -1) SHALL bypass DIV, going IDLE to DONE with out_valid 1 cycle after acceptance.
- Divide-by-zero results: quotient all-ones, remainder equal to the dividend.
- Signed-overflow results: quotient equal to the dividend, remainder 0.
REQ-021 Signed operations SHALL divide magnitudes and then correct signs: quotient sign = XOR of the operand signs; remainder sign = dividend sign.
REQ-022 MUL SHALL return the low XLEN bits of the 2*XLEN product. MULH, MULHSU and MULHU SHALL return the high XLEN bits, treating operands as signed×signed, signed×unsigned and unsigned×unsigned respectively.
REQ-023 DONE SHALL last exactly one cycle with out_valid=1, then return to IDLE. in_valid during DONE SHALL be ignored.
REQ-024 out_stall SHALL be combinational: 1 when (IDLE and in_valid and not in_flush) or state is MUL or DIV; 0 otherwise, including in DONE.
REQ-025 out_result and out_rd SHALL hold their last values while out_valid is 0.
REQ-026 in_flush=1 in any state SHALL force IDLE on the next edge with no out_valid pulse. Flush SHALL win over a same-cycle accept, and over DONE, suppressing that pulse.
REQ-027 Back-to-back operations SHALL be separated by at least one IDLE cycle after DONE.

Reset
REQ-028 With reset=0 at a clk edge, the module SHALL set state=IDLE, out_valid=0, out_result=0, out_rd=0 and clear the iteration counter, regardless of in-flight work. out_stall and out_busy SHALL be 0 in the following cycle.
REQ-029 Reset SHALL take priority over in_flush and over acceptance.

Verification
REQ-030 MUL, XLEN=32, MUL_STAGES=2, rs1=0x0000_0007, rs2=0xFFFF_FFFD -> out_valid at cycle 2, out_result=0xFFFF_FFEB; MULH on the same operands -> 0xFFFF_FFFF.
REQ-031 DIV -7/2 -> out_valid at cycle 33, result 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; out_stall=1 for cycles 0..32.
REQ-032 DIVU 5/0 -> 0xFFFF_FFFF at cycle 1; REM 0x8000_0000 / 0xFFFF_FFFF -> 0 at cycle 1; DIV on the same operands -> 0x8000_0000.
REQ-033 Forwarding with EXMEM rd=5 (we=1, data 0x10), MEMWB rd=5 (we=1, data 0x20), rs1=5 -> operand 0x10; with rs1=0 -> register-file value used.
REQ-034 in_flush at DIV cycle 10 -> IDLE next edge, no out_valid, out_stall=0; reset=0 at DIV cycle 10 -> all outputs 0 next cycle.
